// File: rtl/accel_pkg.sv
// Shared accelerator control types, encoding constants and the control-word encoder
// used by both the command-side encoder and the decode stage.
package accel_pkg;

  localparam int ACCEL_UNIT_COUNT = 4;
  localparam int UNIT_ID_W        = 4;

  localparam logic [2:0] CTRL_OP_NOP     = 3'b000;
  localparam logic [2:0] CTRL_OP_LOAD    = 3'b001;
  localparam logic [2:0] CTRL_OP_STORE   = 3'b010;
  localparam logic [2:0] CTRL_OP_COMPUTE = 3'b011;
  localparam logic [2:0] CTRL_OP_COPY    = 3'b100;
  localparam logic [2:0] CTRL_OP_ADD_VEC = 3'b101;

  localparam logic [1:0] CTRL_COMP_ADD  = 2'b00;
  localparam logic [1:0] CTRL_COMP_MUL  = 2'b01;
  localparam logic [1:0] CTRL_COMP_TANH = 2'b10;
  localparam logic [1:0] CTRL_COMP_RELU = 2'b11;

  localparam int ERR_OP_BIT   = 1;
  localparam int ERR_UNIT_BIT = 0;

  typedef logic [UNIT_ID_W-1:0] unit_id_t;

  typedef struct packed {
    logic [2:0] op_code;
    logic [1:0] comp_type;
    unit_id_t   unit_id;
    unit_id_t   src_unit_id;
  } decoded_ctrl_t;

  typedef struct packed {
    logic [5:0] ctrl;
    unit_id_t   unit_id;
    unit_id_t   src_unit_id;
  } ctrl_packet_t;

  typedef struct packed {
    decoded_ctrl_t cmd;
    logic          bcast;
  } ctrl_fifo_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_EXPAND = 2'd2
  } enc_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= CTRL_OP_ADD_VEC);
  endfunction

  // COPY and ADD_VEC read a source unit, so they carry a meaningful src_unit_id.
  function automatic logic op_has_src(input logic [2:0] op);
    return (op == CTRL_OP_COPY) || (op == CTRL_OP_ADD_VEC);
  endfunction

  function automatic ctrl_packet_t encode_ctrl(input decoded_ctrl_t cmd, input unit_id_t uid);
    ctrl_packet_t pkt;
    logic [2:0]   op_bits;
    unique case (cmd.op_code)
      CTRL_OP_LOAD:    op_bits = CTRL_OP_LOAD;
      CTRL_OP_STORE:   op_bits = CTRL_OP_STORE;
      CTRL_OP_COMPUTE: op_bits = CTRL_OP_COMPUTE;
      CTRL_OP_COPY:    op_bits = CTRL_OP_COPY;
      CTRL_OP_ADD_VEC: op_bits = CTRL_OP_ADD_VEC;
      default:         op_bits = CTRL_OP_NOP;
    endcase
    pkt.ctrl        = {op_bits, cmd.comp_type, 1'b0};
    pkt.unit_id     = uid;
    pkt.src_unit_id = cmd.src_unit_id;
    return pkt;
  endfunction

endpackage

// File: rtl/ctrl_cmd_fifo.sv
// Synchronous command FIFO; extra pointer MSB separates full from empty.
module ctrl_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  T     wr_data,
  input  logic rd_en,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (wr_en) r_wptr <= r_wptr + 1'b1;
      if (rd_en) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = r_mem[r_rptr[AW-1:0]];
  assign empty   = (r_wptr == r_rptr);
  assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/ctrl_encoder.sv
// Validates and buffers host control commands, encodes them into control packets and
// issues them over valid/ready, expanding broadcasts into one packet per eligible unit.
module ctrl_encoder
  import accel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int UNIT_COUNT = ACCEL_UNIT_COUNT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  decoded_ctrl_t cmd_in,
  input  logic          cmd_bcast,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output ctrl_packet_t  ctrl_packet,
  output logic          busy,
  output logic [1:0]    err_status,
  input  logic          err_clear
);

  localparam logic [UNIT_ID_W:0] LP_UC = (UNIT_ID_W+1)'(UNIT_COUNT);

  // First unit at or after 'from' that may receive a broadcast; >= LP_UC means none left.
  function automatic logic [UNIT_ID_W:0] first_elig(input logic [UNIT_ID_W:0] from,
                                                   input logic skip_en, input unit_id_t skip);
    logic [UNIT_ID_W:0] u;
    u = from;
    if (skip_en && (u == {1'b0, skip})) u = u + 1'b1;
    return u;
  endfunction

  enc_state_e         r_state, w_state_nxt;
  ctrl_packet_t       r_pkt, w_pkt_nxt;
  logic               r_pkt_valid, w_valid_nxt;
  decoded_ctrl_t      r_cmd, w_cmd_nxt;
  unit_id_t           r_unit_cnt, w_cnt_nxt;
  logic [1:0]         r_err;
  logic [1:0]         w_err_set;

  ctrl_fifo_entry_t   w_wr_entry, w_head;
  logic               w_full, w_empty, w_push, w_pop, w_load_head;
  logic               w_cmd_hs, w_pkt_hs, w_bad_op, w_bad_unit;
  logic [UNIT_ID_W:0] w_head_first, w_next_unit;

  assign w_cmd_hs   = cmd_valid && cmd_ready;
  assign w_pkt_hs   = r_pkt_valid && pkt_ready;
  assign w_bad_op   = !op_is_legal(cmd_in.op_code);
  assign w_bad_unit = (!cmd_bcast && ({1'b0, cmd_in.unit_id} >= LP_UC)) ||
                      (op_has_src(cmd_in.op_code) && ({1'b0, cmd_in.src_unit_id} >= LP_UC));
  assign w_push     = w_cmd_hs && !w_bad_op && !w_bad_unit;
  assign w_wr_entry = '{cmd: cmd_in, bcast: cmd_bcast};

  ctrl_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (ctrl_fifo_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_push),
    .wr_data (w_wr_entry),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_head_first = first_elig('0, op_has_src(w_head.cmd.op_code), w_head.cmd.src_unit_id);
  assign w_next_unit  = first_elig({1'b0, r_unit_cnt} + 1'b1, op_has_src(r_cmd.op_code),
                                   r_cmd.src_unit_id);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pkt       <= '0;
      r_pkt_valid <= 1'b0;
      r_cmd       <= '0;
      r_unit_cnt  <= '0;
      r_err       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pkt       <= w_pkt_nxt;
      r_pkt_valid <= w_valid_nxt;
      r_cmd       <= w_cmd_nxt;
      r_unit_cnt  <= w_cnt_nxt;
      r_err       <= err_clear ? 2'b00 : (r_err | w_err_set);
    end
  end

  always_comb begin
    w_err_set               = '0;
    w_err_set[ERR_OP_BIT]   = w_cmd_hs && w_bad_op;
    w_err_set[ERR_UNIT_BIT] = w_cmd_hs && w_bad_unit;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pkt_nxt   = r_pkt;
    w_valid_nxt = r_pkt_valid;
    w_cmd_nxt   = r_cmd;
    w_cnt_nxt   = r_unit_cnt;
    w_pop       = 1'b0;
    w_load_head = 1'b0;

    unique case (r_state)
      ST_IDLE:   w_load_head = !w_empty;
      ST_ISSUE:  if (w_pkt_hs) w_load_head = !w_empty;
      ST_EXPAND: begin
        if (w_pkt_hs) begin
          if (w_next_unit < LP_UC) begin
            w_pkt_nxt = encode_ctrl(r_cmd, w_next_unit[UNIT_ID_W-1:0]);
            w_cnt_nxt = w_next_unit[UNIT_ID_W-1:0];
          end else begin
            w_load_head = !w_empty;
          end
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase

    // A finished packet with nothing queued behind it drops back to idle.
    if ((r_state != ST_IDLE) && w_pkt_hs && !w_load_head &&
        !((r_state == ST_EXPAND) && (w_next_unit < LP_UC))) begin
      w_state_nxt = ST_IDLE;
      w_valid_nxt = 1'b0;
    end

    if (w_load_head) begin
      w_pop = 1'b1;
      if (!w_head.bcast) begin
        w_pkt_nxt   = encode_ctrl(w_head.cmd, w_head.cmd.unit_id);
        w_valid_nxt = 1'b1;
        w_state_nxt = ST_ISSUE;
      end else if (w_head_first < LP_UC) begin
        w_pkt_nxt   = encode_ctrl(w_head.cmd, w_head_first[UNIT_ID_W-1:0]);
        w_cmd_nxt   = w_head.cmd;
        w_cnt_nxt   = w_head_first[UNIT_ID_W-1:0];
        w_valid_nxt = 1'b1;
        w_state_nxt = ST_EXPAND;
      end else begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    end
  end

  assign cmd_ready   = !w_full;
  assign pkt_valid   = r_pkt_valid;
  assign ctrl_packet = r_pkt;
  assign busy        = !w_empty || r_pkt_valid || (r_state != ST_IDLE);
  assign err_status  = r_err;

endmodule

// File: tb/tb_ctrl_encoder.sv
// Scoreboard bench for ctrl_encoder: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_ctrl_encoder;
  import accel_pkg::*;

  localparam int UC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  decoded_ctrl_t cmd_in;
  logic          cmd_bcast;
  logic          pkt_valid;
  logic          pkt_ready;
  ctrl_packet_t  ctrl_packet;
  logic          busy;
  logic [1:0]    err_status;
  logic          err_clear;

  always #5 clk = ~clk;

  ctrl_encoder #(.FIFO_DEPTH(4), .UNIT_COUNT(UC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_in      (cmd_in),
    .cmd_bcast   (cmd_bcast),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .ctrl_packet (ctrl_packet),
    .busy        (busy),
    .err_status  (err_status),
    .err_clear   (err_clear)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  ctrl_packet_t exp_q[$];
  logic [1:0]   exp_err;
  bit           hold_prev = 1'b0;
  ctrl_packet_t hold_pkt;

  logic [2:0] OP_BITS   [0:5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
  logic [1:0] COMP_BITS [0:3] = '{2'b00, 2'b01, 2'b10, 2'b11};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_packet_t mk_pkt(input int op, input int comp, input int uid, input int src);
    ctrl_packet_t p;
    p.ctrl        = {OP_BITS[op], COMP_BITS[comp], 1'b0};
    p.unit_id     = unit_id_t'(uid);
    p.src_unit_id = unit_id_t'(src);
    return p;
  endfunction

  // Reference: what one accepted command should produce.
  task automatic model_accept(input int op, input int comp, input int uid, input int src,
                              input bit bcast);
    bit bad_op, has_src, bad_unit;
    bad_op   = (op > 5);
    has_src  = (op == 4) || (op == 5);
    bad_unit = (!bcast && uid >= UC) || (has_src && src >= UC);
    if (bad_op)   exp_err[1] = 1'b1;
    if (bad_unit) exp_err[0] = 1'b1;
    if (err_clear) exp_err = 2'b00;
    if (bad_op || bad_unit) return;
    if (bcast) begin
      for (int u = 0; u < UC; u++)
        if (!(has_src && u == src)) exp_q.push_back(mk_pkt(op, comp, u, src));
    end else begin
      exp_q.push_back(mk_pkt(op, comp, uid, src));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; offers one command for one cycle.
  task automatic send(input int op, input int comp, input int uid, input int src,
                      input bit bcast, output bit acc);
    cmd_valid             = 1'b1;
    cmd_in.op_code        = 3'(op);
    cmd_in.comp_type      = 2'(comp);
    cmd_in.unit_id        = unit_id_t'(uid);
    cmd_in.src_unit_id    = unit_id_t'(src);
    cmd_bcast             = bcast;
    @(negedge clk);
    acc = cmd_ready;
    @(posedge clk);
    if (acc) model_accept(op, comp, uid, src, bcast);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      step();
      k++;
    end
    check("drain_in_budget", 32'(k < budget), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    @(negedge clk);
    while (!pkt_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("valid_in_budget", 32'(pkt_valid), 32'd1);
  endtask

  // Monitor: compare each handshaken packet and check held packets stay stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) check("hold_stable", {pkt_valid, ctrl_packet}, {1'b1, hold_pkt});
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pkt: got 0x%0h, expected no packet at %0t", ctrl_packet, $time);
        end else begin
          check("pkt", ctrl_packet, exp_q.pop_front());
        end
      end
      hold_prev = pkt_valid && !pkt_ready;
      hold_pkt  = ctrl_packet;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_in    = '0;
    cmd_bcast = 1'b0;
    pkt_ready = 1'b0;
    err_clear = 1'b0;
    exp_err   = 2'b00;
    repeat (3) step();
    check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check("rst_ctrl_packet", 32'(ctrl_packet), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_status), 32'd0);
    rst_n = 1'b1;
    step();

    // Unicast COMPUTE/TANH to unit 2, two-cycle latency.
    pkt_ready = 1'b1;
    send(3, 2, 2, 0, 1'b0, acc);
    check("t1_acc", 32'(acc), 32'd1);
    @(negedge clk);
    check("t1_valid_n1", 32'(pkt_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_n2", 32'(pkt_valid), 32'd1);
    check("t1_ctrl", 32'(ctrl_packet.ctrl), 32'(6'b011100));
    check("t1_unit", 32'(ctrl_packet.unit_id), 32'd2);
    step();
    wait_drain(20);

    // Broadcast COPY src=1 -> units 0,2,3 back to back.
    send(4, 1, 3, 1, 1'b1, acc);
    check("t2_acc", 32'(acc), 32'd1);
    wait_valid(10);
    @(negedge clk);
    check("t2_valid_2nd", 32'(pkt_valid), 32'd1);
    @(negedge clk);
    check("t2_valid_3rd", 32'(pkt_valid), 32'd1);
    @(negedge clk);
    check("t2_busy_fall", 32'(busy), 32'd0);
    check("t2_valid_fall", 32'(pkt_valid), 32'd0);
    step();
    wait_drain(20);

    // Stall: 5 accepts fill FIFO plus output register, 6th refused.
    pkt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(1 + (i % 2), i % 4, i % 4, 0, 1'b0, acc);
      check("t3_acc", 32'(acc), 32'd1);
    end
    send(2, 3, 1, 0, 1'b0, acc);
    check("t3_refused", 32'(acc), 32'd0);
    check("t3_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (3) step();
    pkt_ready = 1'b1;
    wait_drain(40);

    // Illegal commands and sticky errors.
    send(5, 0, 0, 5, 1'b0, acc);
    check("t4_acc", 32'(acc), 32'd1);
    @(negedge clk);
    check("t4_err_unit", 32'(err_status), 32'(exp_err));
    check("t4_err_unit_lit", 32'(err_status), 32'd1);
    check("t4_no_pkt", 32'(pkt_valid), 32'd0);
    step();
    send(7, 0, 0, 0, 1'b0, acc);
    @(negedge clk);
    check("t4_err_both", 32'(err_status), 32'd3);
    step();
    err_clear = 1'b1;
    send(7, 0, 9, 0, 1'b0, acc);
    err_clear = 1'b0;
    @(negedge clk);
    check("t4_clear_priority", 32'(err_status), 32'(exp_err));
    check("t4_cleared", 32'(err_status), 32'd0);
    step();
    wait_drain(20);

    // Reset during a broadcast drops the remainder.
    send(5, 3, 0, 2, 1'b1, acc);
    wait_valid(10);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_err = 2'b00;
    #1;
    check("t5_rst_valid", 32'(pkt_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ready", 32'(cmd_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    send(0, 1, 3, 0, 1'b0, acc);
    check("t5_acc", 32'(acc), 32'd1);
    wait_drain(20);
    repeat (5) step();

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      pkt_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0)
        send($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 5),
             $urandom_range(0, 5), ($urandom_range(0, 3) == 0), acc);
      else
        step();
    end
    pkt_ready = 1'b1;
    wait_drain(200);
    check("rand_err", 32'(err_status), 32'(exp_err));
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_encoder.md
# ctrl_encoder

Command-side counterpart of the accelerator control decoder. It accepts decoded control commands (`decoded_ctrl_t`) from the host sequencer and buffers them in a small FIFO. It validates each command, encodes it into `ctrl_packet_t`, and issues packets over a valid/ready handshake toward the decode stage. Broadcast commands expand into one packet per compute unit.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `UNIT_COUNT`, default from `accel_pkg`: number of addressable units.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: command accepted when high together with `cmd_valid`.
- `cmd_in`, in, `decoded_ctrl_t`: `op_code`, `comp_type`, `unit_id`, `src_unit_id`.
- `cmd_bcast`, in, 1: broadcast to all units; `cmd_in.unit_id` is ignored.
- `pkt_valid`, out, 1: `ctrl_packet` holds a valid packet.
- `pkt_ready`, in, 1: downstream accepts the packet.
- `ctrl_packet`, out, `ctrl_packet_t`: encoded packet.
- `busy`, out, 1: FIFO non-empty, or expansion in progress, or `pkt_valid` high.
- `err_status`, out, 2: sticky errors. Bit 1 is an illegal `op_code`. Bit 0 is an illegal `unit_id` or `src_unit_id`.
- `err_clear`, in, 1: clears `err_status`.

## Operation
**Encoding**
- `ctrl[5:3]`: NOP=000, LOAD=001, STORE=010, COMPUTE=011, COPY=100, ADD_VEC=101.
- `ctrl[2:1]`: ADD=00, MUL=01, TANH=10, RELU=11.
- `ctrl[0]` = 0.
- `unit_id` and `src_unit_id` are copied verbatim.

**Validation at enqueue**
- Reject if `op_code` is not one of the six legal values; set err bit 1.
- Reject if `!cmd_bcast` and `unit_id >= UNIT_COUNT`; set err bit 0.
- Reject if `op_code` is COPY or ADD_VEC and `src_unit_id >= UNIT_COUNT`; set err bit 0.
- A rejected command is consumed by the handshake but not enqueued, and produces no packet.

**Flow control**
- `cmd_ready` = FIFO not full. This holds even for commands that will be rejected.

**FSM**
- IDLE: when the FIFO is non-empty, pop the head.
  - Unicast: load the output register and go to ISSUE.
  - Broadcast: set `unit_cnt` to the first eligible unit and go to EXPAND.
- ISSUE: hold `pkt_valid` with a stable packet until `pkt_ready`. On that handshake:
  - if the FIFO is non-empty, pop and load the next packet in the same cycle (stay in ISSUE or go to EXPAND);
  - otherwise go to IDLE.
- EXPAND: issue a packet with `unit_id = unit_cnt`. On each handshake, advance to the next eligible unit.
  - After unit `UNIT_COUNT-1` has been issued, behave as the end of ISSUE.
  - For COPY and ADD_VEC, the unit equal to `src_unit_id` is not eligible (no self-copy).

**Error flags**
- `err_clear` has priority over a new error set in the same cycle.

## Timing
- Reset values: `pkt_valid`=0, `ctrl_packet`='0, `cmd_ready`=1, `busy`=0, `err_status`=00, FSM=IDLE, FIFO empty.
- Latency: command accepted in cycle N with the FIFO empty and the FSM idle → `pkt_valid` high in cycle N+2.
- Throughput: one packet per cycle while `pkt_ready` is held high. There are no bubbles between FIFO entries or within an expansion.
- `ctrl_packet` must not change while `pkt_valid && !pkt_ready`.
- Simultaneous enqueue and dequeue when the FIFO is full:
  - `cmd_ready` is computed from the registered full flag, so it is low that cycle;
  - no entry is lost or duplicated.
- Pointers wrap modulo `FIFO_DEPTH`. An extra MSB distinguishes full from empty.
- Reset mid-expansion or mid-handshake immediately returns all state to reset values; the partial broadcast is dropped.

## Structure
- Add to `accel_pkg`:
  - `CTRL_OP_*` and `CTRL_COMP_*` 3-bit and 2-bit encoding constants shared with the decoder;
  - `ERR_OP_BIT`=1 and `ERR_UNIT_BIT`=0;
  - an `encode_ctrl()` function.
- Sub-module `ctrl_cmd_fifo`: a synchronous FIFO parameterized by depth and payload type. Payload is `decoded_ctrl_t` plus the `bcast` bit.
- FSM and output register stay in `ctrl_encoder`.

## Test plan
All scenarios run with `UNIT_COUNT`=4.
- Unicast COMPUTE/TANH to unit 2, `pkt_ready`=1 → packet with `ctrl`=6'b011100 and `unit_id`=2, exactly 2 cycles after acceptance.
- Broadcast COPY with src=1, `pkt_ready`=1 → three consecutive packets with `unit_id` 0, 2, 3 and `ctrl`=6'b100xx0, then `busy` falls.
- Stall: 5 commands offered with `pkt_ready`=0 → one packet held stable, `cmd_ready` low after 4 (FIFO) + 1 (output register) accepts. Release `pkt_ready` → all 5 packets emerge in order, none lost.
- Illegal command: ADD_VEC with src=5 → `cmd_ready` handshake completes, no packet, `err_status`=01. Then `op_code`=3'b111 → `err_status`=11. Then `err_clear` → 00.
- Reset asserted during broadcast after the first packet → `pkt_valid`=0 and `busy`=0 on reset. After release, a new unicast packet issues correctly with no residual broadcast packets.
